// File: rtl/fir_mac_seq.sv
// Sequential single-multiplier FIR: one sample in, TAPS MAC cycles, round/shift, result out.
// Define FIR_MAC_SATURATE_EN to clamp the output; otherwise the output wraps to OUT_WIDTH bits.
module fir_mac_seq #(
    parameter int DATA_WIDTH = 24,
    parameter int COEF_WIDTH = 16,
    parameter int TAPS       = 8,
    parameter int SHIFT      = 15,
    parameter int OUT_WIDTH  = 24
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic                    i_en,
    input  logic [DATA_WIDTH-1:0]   iv_din,
    input  logic                    i_din_valid,
    output logic                    o_ready,
    input  logic                    i_coef_wr,
    input  logic [$clog2(TAPS)-1:0] iv_coef_addr,
    input  logic [COEF_WIDTH-1:0]   iv_coef,
    output logic [OUT_WIDTH-1:0]    ov_dout,
    output logic                    o_dout_valid,
    input  logic                    i_ready,
    output logic                    o_busy,
    output logic [1:0]              ov_dbg_state
);
    localparam int CNT_W  = $clog2(TAPS);
    localparam int PROD_W = DATA_WIDTH + COEF_WIDTH;
    localparam int ACC_W  = PROD_W + CNT_W;
    localparam logic [ACC_W-1:0]        ONE   = ACC_W'(1);
    localparam logic signed [ACC_W-1:0] RND_C = (ONE << SHIFT) >> 1;
`ifdef FIR_MAC_SATURATE_EN
    localparam logic signed [ACC_W-1:0] OUT_MAX_A = (ONE << (OUT_WIDTH - 1)) - ONE;
    localparam logic signed [ACC_W-1:0] OUT_MIN_A = ~OUT_MAX_A;
`endif

    typedef enum logic [1:0] {IDLE, MAC, ROUND, OUT} state_e;

    // Handshakes: a transfer happens on a rising edge with i_en=1 where valid and ready are both high.
    state_e                             state_q, state_d;
    logic [CNT_W-1:0]                   cnt_q, cnt_d;
    logic signed [ACC_W-1:0]            acc_q, acc_d;
    logic [TAPS-1:0][DATA_WIDTH-1:0]    x_q;
    logic [TAPS-1:0][COEF_WIDTH-1:0]    c_q;
    logic                               ready_q, ready_d;
    logic                               valid_q, valid_d;
    logic [OUT_WIDTH-1:0]               dout_q, dout_d;
    logic                               accept;

    logic signed [PROD_W-1:0]           x_ext, c_ext, prod;
    logic signed [ACC_W-1:0]            prod_ext, rnd_sum, shifted;
    logic [OUT_WIDTH-1:0]               round_out;

    always_comb begin
        x_ext    = {{COEF_WIDTH{x_q[cnt_q][DATA_WIDTH-1]}}, x_q[cnt_q]};
        c_ext    = {{DATA_WIDTH{c_q[cnt_q][COEF_WIDTH-1]}}, c_q[cnt_q]};
        prod     = x_ext * c_ext;
        prod_ext = {{CNT_W{prod[PROD_W-1]}}, prod};
        rnd_sum  = acc_q + RND_C;
        shifted  = rnd_sum >>> SHIFT;
`ifdef FIR_MAC_SATURATE_EN
        if (shifted > OUT_MAX_A) begin
            round_out = OUT_MAX_A[OUT_WIDTH-1:0];
        end else if (shifted < OUT_MIN_A) begin
            round_out = OUT_MIN_A[OUT_WIDTH-1:0];
        end else begin
            round_out = shifted[OUT_WIDTH-1:0];
        end
`else
        round_out = shifted[OUT_WIDTH-1:0];
`endif
    end

`ifndef FIR_MAC_SATURATE_EN
    logic unused_hi;
    assign unused_hi = ^shifted[ACC_W-1:OUT_WIDTH];
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        valid_d = valid_q;
        dout_d  = dout_q;
        accept  = 1'b0;
        case (state_q)
            IDLE: begin
                if (i_din_valid && ready_q) begin
                    accept  = 1'b1;
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = MAC;
                end
            end
            MAC: begin
                acc_d = acc_q + prod_ext;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(TAPS - 1)) begin
                    state_d = ROUND;
                end
            end
            ROUND: begin
                dout_d  = round_out;
                valid_d = 1'b1;
                state_d = OUT;
            end
            OUT: begin
                if (i_ready) begin
                    valid_d = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        // Registered ready: only high while the next state is IDLE.
        ready_d = (state_d == IDLE);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            acc_q   <= '0;
            x_q     <= '0;
            c_q     <= '0;
            ready_q <= 1'b0;
            valid_q <= 1'b0;
            dout_q  <= '0;
        end else if (i_en) begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            ready_q <= ready_d;
            valid_q <= valid_d;
            dout_q  <= dout_d;
            if (accept) begin
                x_q <= {x_q[TAPS-2:0], iv_din};
            end
            // Coefficients are only writable between passes so a MAC pass sees one consistent bank.
            if ((state_q == IDLE) && i_coef_wr) begin
                c_q[iv_coef_addr] <= iv_coef;
            end
        end
    end

    assign o_ready      = ready_q;
    assign o_dout_valid = valid_q;
    assign ov_dout      = dout_q;
    assign o_busy       = (state_q != IDLE);
    assign ov_dbg_state = state_q;

endmodule

// File: tb/tb_fir_mac_seq.sv
// Bench for fir_mac_seq: two instances (SHIFT=0 and SHIFT=1) share stimulus and are checked
// every cycle against a transaction-level dot-product model.
module tb_fir_mac_seq;
  localparam int DW   = 24;
  localparam int CW   = 16;
  localparam int TAPS = 8;
  localparam int OW   = 24;
  localparam int AW   = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic en = 1'b1;
  logic [DW-1:0] din = '0;
  logic din_valid = 1'b0;
  logic coef_wr = 1'b0;
  logic [AW-1:0] coef_addr = '0;
  logic [CW-1:0] coef = '0;
  logic rdy = 1'b1;

  logic ready0, dv0, busy0, ready1, dv1, busy1;
  logic [OW-1:0] dout0, dout1;
  logic [1:0] st0, st1;

  int rdy_mode = 0;
  int en_mode = 0;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fir_mac_seq #(.DATA_WIDTH(DW), .COEF_WIDTH(CW), .TAPS(TAPS), .SHIFT(0), .OUT_WIDTH(OW)) u_dut0 (
    .i_clk(clk), .i_rst_n(rst_n), .i_en(en), .iv_din(din), .i_din_valid(din_valid),
    .o_ready(ready0), .i_coef_wr(coef_wr), .iv_coef_addr(coef_addr), .iv_coef(coef),
    .ov_dout(dout0), .o_dout_valid(dv0), .i_ready(rdy), .o_busy(busy0), .ov_dbg_state(st0)
  );

  fir_mac_seq #(.DATA_WIDTH(DW), .COEF_WIDTH(CW), .TAPS(TAPS), .SHIFT(1), .OUT_WIDTH(OW)) u_dut1 (
    .i_clk(clk), .i_rst_n(rst_n), .i_en(en), .iv_din(din), .i_din_valid(din_valid),
    .o_ready(ready1), .i_coef_wr(coef_wr), .iv_coef_addr(coef_addr), .iv_coef(coef),
    .ov_dout(dout1), .o_dout_valid(dv1), .i_ready(rdy), .o_busy(busy1), .ov_dbg_state(st1)
  );

  // ---------------- reference model ----------------
  longint mx [TAPS];
  longint mc [TAPS];
  longint dot;
  logic m_ready = 1'b0;
  logic m_valid = 1'b0;
  logic m_busy = 1'b0;
  logic acc_pulse = 1'b0;
  int m_since = 0;
  int cyc = 0;
  int acc_cyc = 0;
  int hs_cyc = 0;
  logic [OW-1:0] exp0_q[$];
  logic [OW-1:0] exp1_q[$];
  logic [OW-1:0] got0_q[$];
  logic [OW-1:0] got1_q[$];

  function automatic logic [OW-1:0] model_out(input longint acc, input int sh);
    longint v;
    longint maxv;
    longint minv;
    maxv = (longint'(1) <<< (OW - 1)) - 1;
    minv = -(longint'(1) <<< (OW - 1));
    v = acc;
    if (sh > 0) v = v + (longint'(1) <<< (sh - 1));
    v = v >>> sh;
`ifdef FIR_MAC_SATURATE_EN
    if (v > maxv) v = maxv;
    else if (v < minv) v = minv;
`else
    if (maxv < minv) v = 0;
`endif
    return v[OW-1:0];
  endfunction

  initial begin
    for (int k = 0; k < TAPS; k++) begin
      mx[k] = 0;
      mc[k] = 0;
    end
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        for (int k = 0; k < TAPS; k++) begin
          mx[k] = 0;
          mc[k] = 0;
        end
        m_ready = 1'b0;
        m_valid = 1'b0;
        m_busy = 1'b0;
        m_since = 0;
        acc_pulse = 1'b0;
        exp0_q.delete();
        exp1_q.delete();
      end else begin
        acc_pulse = 1'b0;
        if (en) begin
          if (!m_busy) begin
            if (coef_wr) mc[coef_addr] = longint'($signed(coef));
            if (din_valid && m_ready) begin
              for (int k = TAPS - 1; k > 0; k--) mx[k] = mx[k-1];
              mx[0] = longint'($signed(din));
              dot = 0;
              for (int k = 0; k < TAPS; k++) dot = dot + mx[k] * mc[k];
              exp0_q.push_back(model_out(dot, 0));
              exp1_q.push_back(model_out(dot, 1));
              m_busy = 1'b1;
              m_ready = 1'b0;
              m_since = 0;
              acc_pulse = 1'b1;
              acc_cyc = cyc;
            end else begin
              m_ready = 1'b1;
            end
          end else if (!m_valid) begin
            m_since++;
            if (m_since == TAPS + 1) m_valid = 1'b1;
          end else if (rdy) begin
            got0_q.push_back(dout0);
            got1_q.push_back(dout1);
            if (exp0_q.size() > 0) void'(exp0_q.pop_front());
            if (exp1_q.size() > 0) void'(exp1_q.pop_front());
            m_valid = 1'b0;
            m_busy = 1'b0;
            m_ready = 1'b1;
            hs_cyc = cyc;
          end
          cyc++;
        end
      end
    end
  end

  // ---------------- scoreboard ----------------
  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  initial forever begin
    @(negedge clk);
    chk("ready0", 64'(ready0), 64'(m_ready));
    chk("valid0", 64'(dv0), 64'(m_valid));
    chk("busy0", 64'(busy0), 64'(m_busy));
    chk("ready1", 64'(ready1), 64'(m_ready));
    chk("valid1", 64'(dv1), 64'(m_valid));
    chk("busy1", 64'(busy1), 64'(m_busy));
    if (m_valid && exp0_q.size() > 0) chk("dout0", 64'(dout0), 64'(exp0_q[0]));
    if (m_valid && exp1_q.size() > 0) chk("dout1", 64'(dout1), 64'(exp1_q[0]));
  end

  // ---------------- drivers ----------------
  initial forever begin
    @(posedge clk);
    #1;
    case (rdy_mode)
      0: rdy = 1'b1;
      1: rdy = 1'($urandom_range(0, 1));
      default: rdy = 1'b0;
    endcase
    if (en_mode == 1) en = ($urandom_range(0, 4) != 0);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_coef(input logic [AW-1:0] a, input logic [CW-1:0] v);
    coef_addr = a;
    coef = v;
    coef_wr = 1'b1;
    tick();
    coef_wr = 1'b0;
  endtask

  task automatic wait_accept();
    int n;
    n = 0;
    do begin
      tick();
      n++;
    end while (!acc_pulse && n < 400);
    din_valid = 1'b0;
    if (!acc_pulse) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: got no accept expected accept within 400 cycles at %0t", $time);
    end
  endtask

  task automatic send_sample(input logic [DW-1:0] v);
    din = v;
    din_valid = 1'b1;
    wait_accept();
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (m_busy && n < 400) begin
      tick();
      n++;
    end
    if (m_busy) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: got busy expected idle within 400 cycles at %0t", $time);
    end
  endtask

  function automatic logic [OW-1:0] got0_at(input int i);
    return (i < got0_q.size()) ? got0_q[i] : 'x;
  endfunction

  function automatic logic [OW-1:0] got1_at(input int i);
    return (i < got1_q.size()) ? got1_q[i] : 'x;
  endfunction

  // ---------------- directed + random sequence ----------------
  logic [OW-1:0] imp0 [8] = '{24'd1, 24'd2, 24'd3, 24'd4, 24'd0, 24'd0, 24'd0, 24'd0};
  logic [OW-1:0] imp1 [8] = '{24'd1, 24'd1, 24'd2, 24'd2, 24'd0, 24'd0, 24'd0, 24'd0};
  logic [CW-1:0] imp_c [8] = '{16'd1, 16'd2, 16'd3, 16'd4, 16'd0, 16'd0, 16'd0, 16'd0};
`ifdef FIR_MAC_SATURATE_EN
  localparam logic [OW-1:0] SAT0 = 24'h7FFFFF;
  localparam logic [OW-1:0] SAT1 = 24'h7FFFFF;
`else
  localparam logic [OW-1:0] SAT0 = 24'hFC0008;
  localparam logic [OW-1:0] SAT1 = 24'hFE0004;
`endif

  initial begin
    int mark;
    int n;
    #2 rst_n = 1'b0;
    repeat (3) tick();
    chk("rst_dout0", 64'(dout0), 64'd0);
    chk("rst_valid0", 64'(dv0), 64'd0);
    chk("rst_ready0", 64'(ready0), 64'd0);
    chk("rst_busy0", 64'(busy0), 64'd0);
    chk("rst_state0", 64'(st0), 64'd0);
    chk("rst_state1", 64'(st1), 64'd0);
    rst_n = 1'b1;
    tick();
    chk("ready_after_release", 64'(ready0), 64'd1);

    // impulse
    for (int k = 0; k < TAPS; k++) write_coef(AW'(k), imp_c[k]);
    mark = got0_q.size();
    send_sample(24'd1);
    repeat (7) send_sample(24'd0);
    wait_idle();
    chk("latency", 64'(hs_cyc - acc_cyc), 64'(TAPS + 2));
    for (int i = 0; i < 8; i++) begin
      chk("impulse0", 64'(got0_at(mark + i)), 64'(imp0[i]));
      chk("impulse1", 64'(got1_at(mark + i)), 64'(imp1[i]));
    end

    // backpressure in OUT, with a sample offered meanwhile
    rdy_mode = 2;
    mark = got0_q.size();
    send_sample(24'd100);
    n = 0;
    while (!m_valid && n < 50) begin
      tick();
      n++;
    end
    din = 24'd7;
    din_valid = 1'b1;
    repeat (20) tick();
    chk("bp_valid", 64'(dv0), 64'd1);
    chk("bp_dout", 64'(dout0), 64'd100);
    chk("bp_ready", 64'(ready0), 64'd0);
    rdy_mode = 0;
    wait_accept();
    wait_idle();
    chk("bp_first", 64'(got0_at(mark)), 64'd100);
    chk("bp_second", 64'(got0_at(mark + 1)), 64'd207);

    // rounding: c0=1 only
    for (int k = 1; k < 4; k++) write_coef(AW'(k), 16'd0);
    mark = got0_q.size();
    send_sample(24'd3);
    send_sample(24'hFFFFFD);
    wait_idle();
    chk("round_pos1", 64'(got1_at(mark)), 64'd2);
    chk("round_neg1", 64'(got1_at(mark + 1)), 64'hFFFFFF);
    chk("round_pos0", 64'(got0_at(mark)), 64'd3);
    chk("round_neg0", 64'(got0_at(mark + 1)), 64'hFFFFFD);

    // coefficient write while busy is dropped
    mark = got0_q.size();
    din = 24'd10;
    din_valid = 1'b1;
    wait_accept();
    repeat (3) tick();
    write_coef(3'd0, 16'd9);
    wait_idle();
    send_sample(24'd4);
    wait_idle();
    chk("busywr_a", 64'(got0_at(mark)), 64'd10);
    chk("busywr_b", 64'(got0_at(mark + 1)), 64'd4);
    chk("busywr_b1", 64'(got1_at(mark + 1)), 64'd2);

    // saturation / wrap
    for (int k = 0; k < TAPS; k++) write_coef(AW'(k), 16'h7FFF);
    repeat (8) send_sample(24'h7FFFFF);
    wait_idle();
    chk("sat0", 64'(got0_at(got0_q.size() - 1)), 64'(SAT0));
    chk("sat1", 64'(got1_at(got1_q.size() - 1)), 64'(SAT1));

    // reset in the middle of a MAC pass
    din = 24'd55;
    din_valid = 1'b1;
    wait_accept();
    repeat (3) tick();
    rst_n = 1'b0;
    #1;
    chk("midrst_ready", 64'(ready0), 64'd0);
    chk("midrst_valid", 64'(dv0), 64'd0);
    chk("midrst_busy", 64'(busy0), 64'd0);
    chk("midrst_dout", 64'(dout0), 64'd0);
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    for (int k = 0; k < TAPS; k++) write_coef(AW'(k), 16'd1);
    mark = got0_q.size();
    send_sample(24'd5);
    wait_idle();
    chk("postrst0", 64'(got0_at(mark)), 64'd5);
    chk("postrst1", 64'(got1_at(mark)), 64'd3);

    // randomized traffic with enable and backpressure
    rdy_mode = 1;
    en_mode = 1;
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 3) == 0) write_coef(AW'($urandom_range(0, TAPS - 1)), CW'($urandom_range(0, 65535)));
      repeat ($urandom_range(0, 3)) tick();
      send_sample(DW'($urandom));
    end
    en_mode = 0;
    en = 1'b1;
    rdy_mode = 0;
    tick();
    en = 1'b1;
    wait_idle();
    repeat (3) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
